uart_rx: RTL and testbench

- UART receiver and counterpart of UART_TX: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the serial line.
- Bit timing comes from the same runtime `clock_div` value that drives UART_TX, so a TX/RX pair on one clock runs at matched baud.
- Sits between an external RX pin (asynchronous) and the byte-level host logic.
- Delivers each good byte with a one-cycle strobe, mirroring `tx_done`.

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the async line, times bits from a runtime clock_div
// latched per frame, and reports good bytes / framing errors with one-cycle pulses.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] clock_div,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_error,
  output logic        rx_busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_error_q, rx_error_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic        rxs;
  logic [15:0] half;
  logic [15:0] tgt;
  logic        sample_now;
  logic        sample_bit;
  logic [15:0] cnt_restart;

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign half = {1'b0, div_q[15:1]};
  // Target count of the mid-bit sample: half a bit for start, a full bit otherwise.
  assign tgt  = (state_q == S_START) ? (half - 16'd1) : (div_q - 16'd1);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  // Decision lands one cycle after target; restarting at 1 keeps bit timing on target.
  assign sample_now  = (cnt_q == tgt + 16'd1);
  assign sample_bit  = (maj_q[0] & maj_q[1]) | (maj_q[0] & rxs) | (maj_q[1] & rxs);
  assign cnt_restart = 16'd1;

  always_comb begin
    maj_d = maj_q;
    if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
      if (cnt_q == tgt - 16'd1) maj_d[0] = rxs;
      if (cnt_q == tgt)         maj_d[1] = rxs;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) maj_q <= 2'b11;
    else        maj_q <= maj_d;
  end
`else
  assign sample_now  = (cnt_q == tgt);
  assign sample_bit  = rxs;
  assign cnt_restart = 16'd0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d   = S_START;
          cnt_d     = 16'd0;
          bit_idx_d = 3'd0;
          div_d     = clock_div;
        end
      end
      S_START: begin
        if (sample_now) begin
          if (!sample_bit) begin
            state_d   = S_DATA;
            cnt_d     = cnt_restart;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (sample_now) begin
          shreg_d[bit_idx_q] = sample_bit;
          cnt_d              = cnt_restart;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (sample_now) begin
          cnt_d = 16'd0;
          if (sample_bit) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            rx_error_d = 1'b1;
            state_d    = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_HIGH: begin
        // A held-low break must release before another start can be seen.
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q     <= '1;
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      div_q      <= 16'd0;
      bit_idx_q  <= 3'd0;
      shreg_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_error  = rx_error_q;
  assign rx_busy   = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames cycle by cycle and checks received bytes and
// error pulses against the frames it sent.
module tb_uart_rx;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] clock_div = 16'd217;
  logic        rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_error;
  logic        rx_busy;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc_q[$];
  int         err_pulses = 0;
  int         both_hi = 0;
  int         cyc = 0;
  logic [7:0] last_byte = 8'h00;

  always #5 clock = ~clock;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .clock_div (clock_div),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error),
    .rx_busy   (rx_busy),
    .dbg_state (dbg_state)
  );

  always @(negedge clock) begin
    cyc++;
    if (rx_valid) begin
      obs_q.push_back(rx_data);
      obs_cyc_q.push_back(cyc);
    end
    if (rx_error) err_pulses++;
    if (rx_valid && rx_error) both_hi++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One 10-bit frame, one line value per cycle. glitch_c flips one cycle; rst_c pulses reset.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div,
                            input int glitch_c, input int rst_c, input bit scramble);
    for (int c = 0; c < 10 * div; c++) begin
      int   bi;
      logic v;
      bi = c / div;
      if (bi == 0)      v = 1'b0;
      else if (bi == 9) v = stop_bit;
      else              v = b[bi-1];
      if (c == glitch_c) v = ~v;
      rx = v;
      if (rst_c >= 0 && c == rst_c)     reset = 1'b0;
      if (rst_c >= 0 && c == rst_c + 3) reset = 1'b1;
      if (scramble && c == div) clock_div = 16'($urandom_range(8, 65535));
      tick(1);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(5);
    n_checks++; if (rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_checks++; if (rx_error !== 1'b0) begin n_errors++; $display("FAIL reset_error: got %b want 0", rx_error); end
    n_checks++; if (rx_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    reset = 1'b1;
    tick(5);
    n_checks++; if (rx_busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_single();
    int e0, start_cyc, lat;
    obs_q.delete(); obs_cyc_q.delete();
    e0 = err_pulses;
    start_cyc = cyc;
    send_frame(8'h41, 1'b1, 217, -1, -1, 1'b0);
    tick(20);
    last_byte = 8'h41;
    n_checks++; if (obs_q.size() != 1) begin n_errors++; $display("FAIL single_count: got %0d want 1", obs_q.size()); end
    n_checks++; if (rx_data !== 8'h41) begin n_errors++; $display("FAIL single_data: got %h want 41", rx_data); end
    n_checks++; if (err_pulses != e0) begin n_errors++; $display("FAIL single_err: got %0d want 0", err_pulses - e0); end
    // Falling edge to valid: sync stages + half bit + nine bits + one.
    lat = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] - start_cyc - 1 : -1;
    n_checks++;
    if (lat < 2 + 108 + 9 * 217 + 1 - 3 || lat > 2 + 108 + 9 * 217 + 1 + 3) begin
      n_errors++; $display("FAIL single_latency: got %0d want about %0d", lat, 2 + 108 + 9 * 217 + 1);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    obs_q.delete(); obs_cyc_q.delete();
    send_frame(8'h44, 1'b1, 217, -1, -1, 1'b0);
    send_frame(8'h4D, 1'b1, 217, -1, -1, 1'b0);
    tick(20);
    last_byte = 8'h4D;
    n_checks++; if (obs_q.size() != 2) begin n_errors++; $display("FAIL b2b_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      n_checks++; if (obs_q[0] !== 8'h44) begin n_errors++; $display("FAIL b2b_first: got %h want 44", obs_q[0]); end
      n_checks++; if (obs_q[1] !== 8'h4D) begin n_errors++; $display("FAIL b2b_second: got %h want 4d", obs_q[1]); end
      gap = obs_cyc_q[1] - obs_cyc_q[0];
      n_checks++; if (gap < 2168 || gap > 2172) begin n_errors++; $display("FAIL b2b_spacing: got %0d want 2170", gap); end
    end
  endtask

  task automatic test_glitch();
    int e0, k;
    obs_q.delete();
    e0 = err_pulses;
    rx = 1'b0;
    tick(50);
    n_checks++; if (rx_busy !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_high: got %b want 1", rx_busy); end
    rx = 1'b1;
    k = 50;
    while (rx_busy && k < 120) begin tick(1); k++; end
    n_checks++; if (rx_busy !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_release: busy still %b after %0d cycles", rx_busy, k); end
    tick(10);
    n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL glitch_valid: got %0d pulses want 0", obs_q.size()); end
    n_checks++; if (err_pulses != e0) begin n_errors++; $display("FAIL glitch_error: got %0d pulses want 0", err_pulses - e0); end
  endtask

  task automatic test_break();
    int e0;
    obs_q.delete();
    e0 = err_pulses;
    send_frame(8'h55, 1'b0, 217, -1, -1, 1'b0);
    rx = 1'b0;
    tick(3000);
    n_checks++; if (rx_busy !== 1'b1) begin n_errors++; $display("FAIL break_busy_low: got %b want 1", rx_busy); end
    n_checks++; if (err_pulses - e0 != 1) begin n_errors++; $display("FAIL break_error_count: got %0d want 1", err_pulses - e0); end
    n_checks++; if (rx_data !== last_byte) begin n_errors++; $display("FAIL break_data_held: got %h want %h", rx_data, last_byte); end
    rx = 1'b1;
    tick(10);
    n_checks++; if (rx_busy !== 1'b0) begin n_errors++; $display("FAIL break_busy_release: got %b want 0", rx_busy); end
    send_frame(8'h41, 1'b1, 217, -1, -1, 1'b0);
    tick(20);
    last_byte = 8'h41;
    n_checks++; if (obs_q.size() != 1) begin n_errors++; $display("FAIL break_valid_count: got %0d want 1", obs_q.size()); end
    n_checks++; if (rx_data !== 8'h41) begin n_errors++; $display("FAIL break_next_data: got %h want 41", rx_data); end
    n_checks++; if (err_pulses - e0 != 1) begin n_errors++; $display("FAIL break_single_error: got %0d want 1", err_pulses - e0); end
  endtask

  task automatic test_reset_abort();
    int e0;
    obs_q.delete();
    e0 = err_pulses;
    send_frame(8'hFF, 1'b1, 217, -1, 5 * 217 + 108, 1'b0);
    tick(20);
    last_byte = 8'h00;
    n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL abort_valid: got %0d pulses want 0", obs_q.size()); end
    n_checks++; if (rx_data !== 8'h00) begin n_errors++; $display("FAIL abort_data: got %h want 00", rx_data); end
    send_frame(8'h12, 1'b1, 217, -1, -1, 1'b0);
    tick(20);
    last_byte = 8'h12;
    n_checks++; if (obs_q.size() != 1) begin n_errors++; $display("FAIL abort_next_count: got %0d want 1", obs_q.size()); end
    n_checks++; if (rx_data !== 8'h12) begin n_errors++; $display("FAIL abort_next_data: got %h want 12", rx_data); end
    n_checks++; if (err_pulses != e0) begin n_errors++; $display("FAIL abort_error: got %0d want 0", err_pulses - e0); end
  endtask

  task automatic test_sample_glitch();
    logic [7:0] want;
`ifdef UART_RX_MAJORITY_EN
    want = 8'h00;
`else
    want = 8'h04;
`endif
    obs_q.delete();
    // One-cycle high exactly on the mid-point of data bit 2.
    send_frame(8'h00, 1'b1, 217, 217 / 2 + 3 * 217, -1, 1'b0);
    tick(20);
    last_byte = want;
    n_checks++; if (obs_q.size() != 1) begin n_errors++; $display("FAIL midglitch_count: got %0d want 1", obs_q.size()); end
    n_checks++; if (rx_data !== want) begin n_errors++; $display("FAIL midglitch_data: got %h want %h", rx_data, want); end
  endtask

  task automatic test_random();
    int e0, exp_err, div;
    logic [7:0] b;
    logic stop_bit;
    bit scr;
    obs_q.delete();
    exp_q.delete();
    e0 = err_pulses;
    exp_err = 0;
    for (int i = 0; i < 14; i++) begin
      div = $urandom_range(8, 40);
      clock_div = 16'(div);
      b = 8'($urandom);
      stop_bit = ($urandom_range(0, 5) != 0);
      scr = 1'($urandom_range(0, 1));
      send_frame(b, stop_bit, div, -1, -1, scr);
      clock_div = 16'(div);
      if (stop_bit) begin
        exp_q.push_back(b);
        last_byte = b;
        tick($urandom_range(0, 3));
      end else begin
        exp_err++;
        tick($urandom_range(4, 8));
      end
    end
    tick(50);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rand_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (err_pulses - e0 != exp_err) begin n_errors++; $display("FAIL rand_errors: got %0d want %0d", err_pulses - e0, exp_err); end
    n_checks++; if (rx_data !== last_byte) begin n_errors++; $display("FAIL rand_last_data: got %h want %h", rx_data, last_byte); end
    n_checks++; if (rx_busy !== 1'b0) begin n_errors++; $display("FAIL rand_idle: got %b want 0", rx_busy); end
  endtask

  task automatic test_exclusive();
    n_checks++; if (both_hi != 0) begin n_errors++; $display("FAIL valid_error_overlap: got %0d cycles want 0", both_hi); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_abort();
    clock_div = 16'd217;
    test_sample_glitch();
    test_random();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
